star_bar_addr_gen: RTL and testbench

- Address generator and level sequencer that sits directly upstream of the star-bar ROM. It drives the ROM's 13-bit read address.
- Converts the current raster position and the game's wanted level into a bank/row/column ROM address. The ROM stores four 1536-pixel banks for 0–3 stars.
- Latches the star level only at frame boundaries, so there is no mid-frame tearing.
- Produces a bar_on flag aligned to the ROM's registered colour output.

---
 rtl/star_bar_addr_gen.sv | 181 ++++++++++++++++++
 tb/tb_star_bar_addr_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/star_bar_addr_gen.sv
// Star-bar ROM address generator with frame-synchronous star-level latching.
// Define STAR_BAR_FLASH_EN to build the IDLE/FLASH blink sequencer for level increases.
module star_bar_addr_gen #(
   parameter int BAR_X0       = 536,
   parameter int BAR_Y0       = 8,
   parameter int BAR_W        = 96,
   parameter int BAR_H        = 16,
   parameter int FLASH_FRAMES = 60,
   parameter int BLINK_FRAMES = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        frame_start,
   input  logic [2:0]  star_level,
   output logic [12:0] read_address,
   output logic        bar_on,
   output logic [1:0]  cur_stars,
   output logic        flashing
);

   localparam logic [9:0]  X_LO  = 10'(BAR_X0);
   localparam logic [9:0]  X_HI  = 10'(BAR_X0 + BAR_W);
   localparam logic [9:0]  Y_LO  = 10'(BAR_Y0);
   localparam logic [9:0]  Y_HI  = 10'(BAR_Y0 + BAR_H);
   localparam logic [12:0] ROW_W = 13'(BAR_W);
   localparam logic [12:0] BANK  = 13'(BAR_W * BAR_H);

   // Each ROM bank holds one 1536-pixel bar image; other geometries would overlap banks.
   if (BAR_W * BAR_H != 1536) begin : g_bad_geometry
      $error("star_bar_addr_gen: BAR_W*BAR_H must equal 1536");
   end
   if (FLASH_FRAMES < 1 || BLINK_FRAMES < 1) begin : g_bad_flash
      $error("star_bar_addr_gen: FLASH_FRAMES and BLINK_FRAMES must be positive");
   end

   logic [1:0]  target_s;
   logic        inside_s;
   logic [12:0] dx_s;
   logic [12:0] dy_s;
   logic [12:0] addr_s;
   logic [12:0] read_address_q;
   logic        inside_q;
   logic        bar_on_q;
   logic [1:0]  cur_stars_q;

   assign target_s = (star_level > 3'd3) ? 2'd3 : star_level[1:0];

   always_comb begin
      inside_s = (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
      dx_s     = {3'b000, DrawX - X_LO};
      dy_s     = {3'b000, DrawY - Y_LO};
      addr_s   = ({11'b000_0000_0000, cur_stars_q} * BANK) + (dy_s * ROW_W) + dx_s;
   end

   // bar_on trails the address by one more cycle to line up with the ROM's registered data.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         read_address_q <= 13'd0;
         inside_q       <= 1'b0;
         bar_on_q       <= 1'b0;
      end else begin
         read_address_q <= inside_s ? addr_s : 13'd0;
         inside_q       <= inside_s;
         bar_on_q       <= inside_q;
      end
   end

`ifdef STAR_BAR_FLASH_EN
   localparam int            CW   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam logic [CW-1:0] LAST = CW'(FLASH_FRAMES - 1);

   typedef enum logic {IDLE = 1'b0, FLASH = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [1:0]    committed_q, committed_d;
   logic [1:0]    prev_q, prev_d;
   logic [CW-1:0] counter_q, counter_d;
   logic [1:0]    cur_stars_d;
   logic          flashing_q, flashing_d;

   always_comb begin
      state_d     = state_q;
      committed_d = committed_q;
      prev_d      = prev_q;
      counter_d   = counter_q;
      if (frame_start) begin
         case (state_q)
            IDLE: begin
               if (target_s > committed_q) begin
                  prev_d      = committed_q;
                  committed_d = target_s;
                  counter_d   = {CW{1'b0}};
                  state_d     = FLASH;
               end else begin
                  committed_d = target_s;
               end
            end
            FLASH: begin
               if (target_s > committed_q) begin
                  prev_d      = committed_q;
                  committed_d = target_s;
                  counter_d   = {CW{1'b0}};
               end else if (target_s < committed_q) begin
                  committed_d = target_s;
                  counter_d   = {CW{1'b0}};
                  state_d     = IDLE;
               end else if (counter_q == LAST) begin
                  counter_d   = {CW{1'b0}};
                  state_d     = IDLE;
               end else begin
                  counter_d   = counter_q + CW'(1);
               end
            end
            default: begin
               counter_d = {CW{1'b0}};
               state_d   = IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
      // Outputs are registered from next-state so cur_stars moves exactly one cycle after frame_start.
      flashing_d = (state_d == FLASH);
      if ((state_d == FLASH) &&
          (((32'(counter_d) / $unsigned(BLINK_FRAMES)) % 32'd2) != 32'd0)) begin
         cur_stars_d = prev_d;
      end else begin
         cur_stars_d = committed_d;
      end
   end

   // Sequencer state and registered level outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         committed_q <= 2'd0;
         prev_q      <= 2'd0;
         counter_q   <= {CW{1'b0}};
         cur_stars_q <= 2'd0;
         flashing_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         committed_q <= committed_d;
         prev_q      <= prev_d;
         counter_q   <= counter_d;
         cur_stars_q <= cur_stars_d;
         flashing_q  <= flashing_d;
      end
   end

   assign flashing = flashing_q;
`else
   logic [1:0] committed_d;

   always_comb begin
      if (frame_start) begin
         committed_d = target_s;
      end else begin
         committed_d = cur_stars_q;
      end
   end

   // Without the sequencer the committed level is the displayed level.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cur_stars_q <= 2'd0;
      end else begin
         cur_stars_q <= committed_d;
      end
   end

   assign flashing = 1'b0;
`endif

   assign read_address = read_address_q;
   assign bar_on       = bar_on_q;
   assign cur_stars    = cur_stars_q;

endmodule

// File: tb/tb_star_bar_addr_gen.sv
// Directed scoreboard bench for star_bar_addr_gen; covers both STAR_BAR_FLASH_EN builds.
module tb_star_bar_addr_gen;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [9:0]  DrawX = 10'd0;
   logic [9:0]  DrawY = 10'd0;
   logic        frame_start = 1'b0;
   logic [2:0]  star_level = 3'd0;
   logic [12:0] read_address;
   logic        bar_on;
   logic [1:0]  cur_stars;
   logic        flashing;

   int total = 0;
   int bad   = 0;
   int model_stars = 0;
   logic [12:0] q_addr[$];
   logic        q_bar[$];

`ifdef STAR_BAR_FLASH_EN
   localparam bit FLASH_ON = 1'b1;
`else
   localparam bit FLASH_ON = 1'b0;
`endif

   star_bar_addr_gen dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .frame_start  (frame_start),
      .star_level   (star_level),
      .read_address (read_address),
      .bar_on       (bar_on),
      .cur_stars    (cur_stars),
      .flashing     (flashing)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit in_bar(input int x, input int y);
      return (x >= 536) && (x < 632) && (y >= 8) && (y < 24);
   endfunction

   function automatic logic [12:0] exp_addr(input int x, input int y, input int s);
      if (in_bar(x, y)) return 13'(s * 1536 + (y - 8) * 96 + (x - 536));
      return 13'd0;
   endfunction

   // Drive one pixel, then an off-bar pixel, so each output is seen only at its own latency.
   task automatic pixel(input int x, input int y);
      logic [12:0] ea;
      logic        eb;
      DrawX = 10'(x);
      DrawY = 10'(y);
      q_addr.push_back(exp_addr(x, y, model_stars));
      q_bar.push_back(in_bar(x, y));
      step();
      ea = q_addr.pop_front();
      chk("read_address", 16'(read_address), 16'(ea));
      DrawX = 10'd0;
      DrawY = 10'd0;
      step();
      eb = q_bar.pop_front();
      chk("bar_on", 16'(bar_on), 16'(eb));
   endtask

   task automatic frame(input int lvl, input int exp_s, input bit exp_f);
      frame_start = 1'b1;
      star_level  = 3'(lvl);
      step();
      frame_start = 1'b0;
      model_stars = exp_s;
      chk("cur_stars", 16'(cur_stars), 16'(exp_s));
      chk("flashing", 16'(flashing), 16'(exp_f));
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step();
      step();
      Reset = 1'b0;
      model_stars = 0;
   endtask

   initial begin
      // Reset and first pixel in bank 0
      DrawX = 10'd536;
      DrawY = 10'd8;
      do_reset();
      chk("rst_read_address", 16'(read_address), 16'd0);
      chk("rst_bar_on", 16'(bar_on), 16'd0);
      chk("rst_cur_stars", 16'(cur_stars), 16'd0);
      chk("rst_flashing", 16'(flashing), 16'd0);
      pixel(536, 8);

      // Level 3, last bar pixel and edges
      frame(3, 3, FLASH_ON);
      pixel(631, 23);
      pixel(632, 23);
      pixel(535, 8);
      pixel(536, 7);
      pixel(536, 24);
      pixel(631, 8);

      // Mid-frame level changes are ignored; saturation at frame_start
      frame(1, 1, 1'b0);
      star_level = 3'd5;
      step();
      step();
      step();
      chk("midframe_cur_stars", 16'(cur_stars), 16'd1);
      frame(5, 3, FLASH_ON);
      pixel(536, 8);
      frame(0, 0, 1'b0);
      frame(2, 2, FLASH_ON);
      pixel(580, 15);

      // Reset coincident with frame_start
      DrawX       = 10'd631;
      DrawY       = 10'd23;
      frame_start = 1'b1;
      star_level  = 3'd3;
      Reset       = 1'b1;
      step();
      Reset       = 1'b0;
      frame_start = 1'b0;
      model_stars = 0;
      chk("rstfs_cur_stars", 16'(cur_stars), 16'd0);
      chk("rstfs_flashing", 16'(flashing), 16'd0);
      chk("rstfs_read_address", 16'(read_address), 16'd0);
      DrawX = 10'd0;
      DrawY = 10'd0;
      step();

`ifdef STAR_BAR_FLASH_EN
      // Full 60-frame flash 0 -> 2
      do_reset();
      frame(2, 2, 1'b1);
      for (int k = 1; k < 60; k++) begin
         frame(2, (((k / 8) % 2) == 0) ? 2 : 0, 1'b1);
      end
      frame(2, 2, 1'b0);
      pixel(536, 8);

      // Abort a 0 -> 3 flash at frame 10 with a drop to level 1
      do_reset();
      frame(3, 3, 1'b1);
      for (int k = 1; k < 10; k++) begin
         frame(3, (k < 8) ? 3 : 0, 1'b1);
      end
      frame(1, 1, 1'b0);

      // Raise during a flash restarts it from counter 0
      frame(2, 2, 1'b1);
      frame(3, 3, 1'b1);

      // Reset mid-flash coincident with frame_start
      DrawX       = 10'd631;
      DrawY       = 10'd23;
      frame_start = 1'b1;
      Reset       = 1'b1;
      step();
      Reset       = 1'b0;
      frame_start = 1'b0;
      chk("flash_rst_cur_stars", 16'(cur_stars), 16'd0);
      chk("flash_rst_flashing", 16'(flashing), 16'd0);
      chk("flash_rst_read_address", 16'(read_address), 16'd0);
`else
      // Without the sequencer a rise shows immediately and never flashes
      frame(2, 2, 1'b0);
      frame(3, 3, 1'b0);
      frame(1, 1, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
